// File: rtl/issue_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | issue_pkg : RV32I opcode constants, issue FSM states, field decode   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package issue_pkg;

  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HAZARD = 2'd2
  } issue_state_e;

  function automatic logic [6:0] get_opcode(input logic [31:0] instr);
    return instr[6:0];
  endfunction

  function automatic logic [4:0] get_rd(input logic [31:0] instr);
    return instr[11:7];
  endfunction

  function automatic logic [4:0] get_rs1(input logic [31:0] instr);
    return instr[19:15];
  endfunction

  function automatic logic [4:0] get_rs2(input logic [31:0] instr);
    return instr[24:20];
  endfunction

endpackage
`default_nettype wire

// File: rtl/issue_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | issue_fifo : synchronous FIFO with clear, occupancy, full/empty      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module issue_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign full    = (r_count == (AW+1)'(DEPTH));
  assign empty   = (r_count == '0);
  assign w_push  = push && !full && !clr;
  assign w_pop   = pop && !empty && !clr;
  assign head    = r_mem[r_rd_ptr];
  assign count   = r_count;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= push_data;
  end

endmodule
`default_nettype wire

// File: rtl/instr_issue_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | instr_issue_ctrl : in-order issue with register scoreboard stall.    |
// | Optional ISSUE_PERF_CNT_EN adds issue_cnt / stall_cnt outputs.       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module instr_issue_ctrl
  import issue_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int WB_LAT     = 2
) (
  input  logic                          cpu_clk,
  input  logic                          cpu_rst_n,
  input  logic                          flush,
  input  logic [31:0]                   in_instr,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          core_busy,
  output logic [31:0]                   cpu_instruction,
  output logic                          cpu_instruction_RDY_BSY,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          stall_hazard,
  output logic                          idle
`ifdef ISSUE_PERF_CNT_EN
  ,
  output logic [31:0]                   issue_cnt,
  output logic [31:0]                   stall_cnt
`endif
);

  localparam int SB_N = WB_LAT - 1;
  localparam int CW   = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]     w_head;
  logic            w_full;
  logic            w_empty;
  logic            w_push;
  logic            w_issue;
  logic            w_hazard;
  logic [6:0]      w_op;
  logic [4:0]      w_rd;
  logic [4:0]      w_rs1;
  logic [4:0]      w_rs2;
  logic            w_use_rs1;
  logic            w_use_rs2;
  logic            w_wr_rd;
  logic [SB_N-1:0] w_match;
  logic [SB_N-1:0] r_sb_valid;
  logic [4:0]      r_sb_rd [SB_N];
  logic [31:0]     r_instr;
  logic            r_strobe;
  issue_state_e    r_state;
  issue_state_e    w_state_nxt;

  assign w_push   = in_valid && !w_full && !flush;
  assign in_ready = !w_full;

  issue_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk       (cpu_clk),
    .rst_n     (cpu_rst_n),
    .clr       (flush),
    .push      (w_push),
    .push_data (in_instr),
    .pop       (w_issue),
    .head      (w_head),
    .count     (fifo_count),
    .full      (w_full),
    .empty     (w_empty)
  );

  assign w_op      = get_opcode(w_head);
  assign w_rd      = get_rd(w_head);
  assign w_rs1     = get_rs1(w_head);
  assign w_rs2     = get_rs2(w_head);
  assign w_use_rs1 = ((w_op == OP_ITYPE) || (w_op == OP_RTYPE)) && (w_rs1 != 5'd0);
  assign w_use_rs2 = (w_op == OP_RTYPE) && (w_rs2 != 5'd0);
  assign w_wr_rd   = ((w_op == OP_ITYPE) || (w_op == OP_RTYPE)) && (w_rd != 5'd0);

  generate
    for (genvar i = 0; i < SB_N; i++) begin : g_sb_cmp
      assign w_match[i] = r_sb_valid[i] &&
                          ((w_use_rs1 && (r_sb_rd[i] == w_rs1)) ||
                           (w_use_rs2 && (r_sb_rd[i] == w_rs2)));
    end
  endgenerate

  assign w_hazard     = !w_empty && (|w_match);
  assign w_issue      = !w_empty && !core_busy && !w_hazard && !flush;
  assign stall_hazard = w_hazard;

  // Scoreboard ages every cycle; an entry lives WB_LAT-1 cycles after issue.
  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      r_sb_valid <= '0;
      for (int i = 0; i < SB_N; i++) r_sb_rd[i] <= 5'd0;
    end else if (flush) begin
      r_sb_valid <= '0;
    end else begin
      r_sb_valid[0] <= w_issue && w_wr_rd;
      r_sb_rd[0]    <= w_rd;
      for (int i = 1; i < SB_N; i++) begin
        r_sb_valid[i] <= r_sb_valid[i-1];
        r_sb_rd[i]    <= r_sb_rd[i-1];
      end
    end
  end

  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      r_instr  <= 32'd0;
      r_strobe <= 1'b0;
    end else begin
      r_strobe <= w_issue;
      if (w_issue) r_instr <= w_head;
    end
  end

  assign cpu_instruction         = r_instr;
  assign cpu_instruction_RDY_BSY = r_strobe;

  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) r_state <= IDLE;
    else            r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE:        if (w_push) w_state_nxt = RUN;
        RUN, HAZARD: begin
          if (w_issue && (fifo_count == CW'(1)) && !w_push) w_state_nxt = IDLE;
          else if (w_hazard)                                w_state_nxt = HAZARD;
          else                                              w_state_nxt = RUN;
        end
        default:     w_state_nxt = IDLE;
      endcase
    end
  end

  // IDLE state tracks an empty buffer, so idle only needs the scoreboard added.
  assign idle = (r_state == IDLE) && !(|r_sb_valid);

`ifdef ISSUE_PERF_CNT_EN
  logic [31:0] r_issue_cnt;
  logic [31:0] r_stall_cnt;

  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      r_issue_cnt <= 32'd0;
      r_stall_cnt <= 32'd0;
    end else if (flush) begin
      r_issue_cnt <= 32'd0;
      r_stall_cnt <= 32'd0;
    end else begin
      if (w_issue)             r_issue_cnt <= r_issue_cnt + 32'd1;
      if (!w_empty && !w_issue) r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign issue_cnt = r_issue_cnt;
  assign stall_cnt = r_stall_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_instr_issue_ctrl.sv
`default_nettype none
// Testbench for instr_issue_ctrl: directed scenarios plus randomized traffic
// checked against a register-ready-time reference model.
module tb_instr_issue_ctrl;

  localparam int DEPTH = 4;
  localparam int WBL   = 2;

  logic        cpu_clk   = 1'b0;
  logic        cpu_rst_n = 1'b0;
  logic        flush     = 1'b0;
  logic        in_valid  = 1'b0;
  logic        core_busy = 1'b0;
  logic [31:0] in_instr  = 32'd0;
  logic        in_ready;
  logic [31:0] cpu_instruction;
  logic        cpu_instruction_RDY_BSY;
  logic [2:0]  fifo_count;
  logic        stall_hazard;
  logic        idle;

  instr_issue_ctrl #(.FIFO_DEPTH(DEPTH), .WB_LAT(WBL)) dut (
    .cpu_clk                 (cpu_clk),
    .cpu_rst_n               (cpu_rst_n),
    .flush                   (flush),
    .in_instr                (in_instr),
    .in_valid                (in_valid),
    .in_ready                (in_ready),
    .core_busy               (core_busy),
    .cpu_instruction         (cpu_instruction),
    .cpu_instruction_RDY_BSY (cpu_instruction_RDY_BSY),
    .fifo_count              (fifo_count),
    .stall_hazard            (stall_hazard),
    .idle                    (idle)
  );

  always #5 cpu_clk = ~cpu_clk;

  int total = 0;
  int bad   = 0;
  int k     = 0;

  // Model: FIFO contents plus, per register, the first edge at which a
  // consumer may issue (producer issue edge + WB_LAT).
  logic [31:0] q[$];
  int          rdy[32];
  logic [31:0] m_instr  = 32'd0;
  logic        m_strobe = 1'b0;

  function automatic bit m_hazard();
    logic [31:0] h;
    if (q.size() == 0) return 1'b0;
    h = q[0];
    if ((h[6:0] == 7'b0010011 || h[6:0] == 7'b0110011) && h[19:15] != 5'd0 && rdy[h[19:15]] > k + 1) return 1'b1;
    if (h[6:0] == 7'b0110011 && h[24:20] != 5'd0 && rdy[h[24:20]] > k + 1) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_idle();
    if (q.size() != 0) return 1'b0;
    foreach (rdy[r]) if (rdy[r] > k + 1) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    q.delete();
    foreach (rdy[r]) rdy[r] = 0;
    m_instr  = 32'd0;
    m_strobe = 1'b0;
  endtask

  // Applies one cycle of inputs, crosses the edge, advances the model.
  task automatic drive_cycle(input bit v, input logic [31:0] ins, input bit busy, input bit fl);
    bit          iss, psh;
    logic [31:0] h;
    in_valid  = v;
    in_instr  = ins;
    core_busy = busy;
    flush     = fl;
    iss = (q.size() != 0) && !busy && !m_hazard() && !fl;
    psh = v && (q.size() < DEPTH) && !fl;
    h   = (q.size() != 0) ? q[0] : 32'd0;
    @(posedge cpu_clk);
    #1;
    k++;
    if (fl) begin
      q.delete();
      foreach (rdy[r]) rdy[r] = 0;
      m_strobe = 1'b0;
    end else begin
      if (iss) begin
        void'(q.pop_front());
        m_instr  = h;
        m_strobe = 1'b1;
        if ((h[6:0] == 7'b0010011 || h[6:0] == 7'b0110011) && h[11:7] != 5'd0) rdy[h[11:7]] = k + WBL;
      end else begin
        m_strobe = 1'b0;
      end
      if (psh) q.push_back(ins);
    end
    in_valid  = 1'b0;
    flush     = 1'b0;
    core_busy = 1'b0;
  endtask

  task automatic settle();
    for (int i = 0; i < DEPTH + WBL + 2; i++) drive_cycle(1'b0, 32'd0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    total++;
    if ({cpu_instruction, cpu_instruction_RDY_BSY, fifo_count, stall_hazard, idle, in_ready} !==
        {32'd0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1}) begin
      bad++;
      $display("FAIL reset_values: got instr=%h stb=%b cnt=%0d hz=%b idle=%b rdy=%b", cpu_instruction,
               cpu_instruction_RDY_BSY, fifo_count, stall_hazard, idle, in_ready);
    end
  endtask

  task automatic test_single();
    settle();
    drive_cycle(1'b1, 32'h00500093, 1'b0, 1'b0);
    total++;
    if ({fifo_count, cpu_instruction_RDY_BSY, idle} !== {3'd1, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL single_accept: got cnt=%0d stb=%b idle=%b exp 1 0 0", fifo_count, cpu_instruction_RDY_BSY, idle);
    end
    drive_cycle(1'b0, 32'd0, 1'b0, 1'b0);
    total++;
    if ({cpu_instruction_RDY_BSY, cpu_instruction, fifo_count, idle} !== {1'b1, 32'h00500093, 3'd0, 1'b0}) begin
      bad++;
      $display("FAIL single_issue: got stb=%b instr=%h cnt=%0d idle=%b", cpu_instruction_RDY_BSY, cpu_instruction, fifo_count, idle);
    end
    drive_cycle(1'b0, 32'd0, 1'b0, 1'b0);
    total++;
    if ({cpu_instruction_RDY_BSY, idle} !== {1'b0, 1'b1}) begin
      bad++;
      $display("FAIL single_idle: got stb=%b idle=%b exp 0 1", cpu_instruction_RDY_BSY, idle);
    end
  endtask

  // Pushes two words back-to-back, records strobe/stall for 5 cycles.
  task automatic run_pair(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] exp_stb, input logic [4:0] exp_hz);
    logic [4:0] sp, hp;
    settle();
    drive_cycle(1'b1, a, 1'b0, 1'b0);
    sp[0] = cpu_instruction_RDY_BSY; hp[0] = stall_hazard;
    drive_cycle(1'b1, b, 1'b0, 1'b0);
    sp[1] = cpu_instruction_RDY_BSY; hp[1] = stall_hazard;
    for (int i = 2; i < 5; i++) begin
      drive_cycle(1'b0, 32'd0, 1'b0, 1'b0);
      sp[i] = cpu_instruction_RDY_BSY; hp[i] = stall_hazard;
    end
    total++;
    if (sp !== exp_stb) begin bad++; $display("FAIL %s_strobes: got=%b exp=%b", name, sp, exp_stb); end
    total++;
    if (hp !== exp_hz) begin bad++; $display("FAIL %s_stall: got=%b exp=%b", name, hp, exp_hz); end
    total++;
    if (cpu_instruction !== b) begin bad++; $display("FAIL %s_last: got=%h exp=%h", name, cpu_instruction, b); end
  endtask

  task automatic test_dependent();
    run_pair("dep_rs1", 32'h00500093, 32'h00508113, 5'b01010, 5'b00010);
  endtask

  task automatic test_back_to_back();
    run_pair("indep", 32'h00500093, 32'h00100293, 5'b00110, 5'b00000);
  endtask

  task automatic test_rs2_dep();
    run_pair("dep_rs2", 32'h002081B3, 32'h00317233, 5'b01010, 5'b00010);
  endtask

  task automatic test_backpressure();
    logic [31:0] w [5];
    settle();
    for (int i = 0; i < 5; i++) begin
      w[i] = 32'h00000013 | ((i + 6) << 7);
      drive_cycle(1'b1, w[i], 1'b1, 1'b0);
    end
    total++;
    if ({fifo_count, in_ready, cpu_instruction_RDY_BSY} !== {3'd4, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL bp_full: got cnt=%0d rdy=%b stb=%b exp 4 0 0", fifo_count, in_ready, cpu_instruction_RDY_BSY);
    end
    for (int r = 0; r < 5; r++) begin
      if (r < 2) drive_cycle(1'b1, w[4], 1'b0, 1'b0);
      else       drive_cycle(1'b0, 32'd0, 1'b0, 1'b0);
      total++;
      if ({cpu_instruction_RDY_BSY, cpu_instruction} !== {1'b1, w[r]}) begin
        bad++;
        $display("FAIL bp_drain%0d: got stb=%b instr=%h exp 1 %h", r, cpu_instruction_RDY_BSY, cpu_instruction, w[r]);
      end
    end
    drive_cycle(1'b0, 32'd0, 1'b0, 1'b0);
    total++;
    if ({cpu_instruction_RDY_BSY, fifo_count} !== {1'b0, 3'd0}) begin
      bad++;
      $display("FAIL bp_end: got stb=%b cnt=%0d exp 0 0", cpu_instruction_RDY_BSY, fifo_count);
    end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) drive_cycle(1'b1, 32'h00000013 | ((i + 11) << 7), 1'b1, 1'b0);
    total++;
    if (fifo_count !== 3'd3) begin bad++; $display("FAIL flush_fill: got cnt=%0d exp 3", fifo_count); end
    drive_cycle(1'b1, 32'h00A00093, 1'b0, 1'b1);
    total++;
    if ({fifo_count, idle, cpu_instruction_RDY_BSY, cpu_instruction} !== {3'd0, 1'b1, 1'b0, 32'h00000513}) begin
      bad++;
      $display("FAIL flush_clear: got cnt=%0d idle=%b stb=%b instr=%h exp 0 1 0 00000513",
               fifo_count, idle, cpu_instruction_RDY_BSY, cpu_instruction);
    end
    drive_cycle(1'b0, 32'd0, 1'b0, 1'b0);
    total++;
    if ({fifo_count, cpu_instruction_RDY_BSY} !== {3'd0, 1'b0}) begin
      bad++;
      $display("FAIL flush_drop: got cnt=%0d stb=%b exp 0 0", fifo_count, cpu_instruction_RDY_BSY);
    end
  endtask

  task automatic test_reset_midop();
    drive_cycle(1'b1, 32'h00500093, 1'b0, 1'b0);
    drive_cycle(1'b1, 32'h00100293, 1'b1, 1'b0);
    cpu_rst_n = 1'b0;
    #1;
    total++;
    if ({fifo_count, cpu_instruction_RDY_BSY, cpu_instruction, idle, in_ready, stall_hazard} !==
        {3'd0, 1'b0, 32'd0, 1'b1, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL reset_midop: got cnt=%0d stb=%b instr=%h idle=%b rdy=%b hz=%b", fifo_count,
               cpu_instruction_RDY_BSY, cpu_instruction, idle, in_ready, stall_hazard);
    end
    @(posedge cpu_clk);
    #1;
    k++;
    cpu_rst_n = 1'b1;
    model_reset();
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    int          s;
    w = $urandom;
    s = $urandom_range(0, 3);
    w[6:0]   = (s == 1) ? 7'b0110011 : (s == 3) ? 7'b0100011 : 7'b0010011;
    w[11:7]  = 5'($urandom_range(0, 3));
    w[19:15] = 5'($urandom_range(0, 3));
    w[24:20] = 5'($urandom_range(0, 3));
    return w;
  endfunction

  task automatic test_random();
    logic [38:0] exp_v, got_v;
    for (int i = 0; i < 500; i++) begin
      drive_cycle($urandom_range(0, 9) < 7, rand_instr(), $urandom_range(0, 3) == 0, $urandom_range(0, 39) == 0);
      exp_v = {m_strobe, m_instr, 3'(q.size()), m_hazard(), m_idle(), q.size() < DEPTH};
      got_v = {cpu_instruction_RDY_BSY, cpu_instruction, fifo_count, stall_hazard, idle, in_ready};
      total++;
      if (got_v !== exp_v) begin
        bad++;
        $display("FAIL random_cyc%0d: got {stb,instr,cnt,hz,idle,rdy}=%h exp=%h", i, got_v, exp_v);
      end
    end
  endtask

  initial begin
    model_reset();
    @(posedge cpu_clk);
    #1;
    test_reset();
    cpu_rst_n = 1'b1;
    test_single();
    test_dependent();
    test_back_to_back();
    test_rs2_dep();
    test_backpressure();
    test_flush();
    test_reset_midop();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/instr_issue_ctrl.md
# instr_issue_ctrl

In-order instruction issue controller between the fetch side (IFU) and the `cpu` core. It buffers incoming 32-bit RV32I instructions in a small FIFO and drives `cpu_instruction` with a one-cycle `cpu_instruction_RDY_BSY` strobe. A register scoreboard holds back any instruction whose source register is still being written by a recently issued producer. It also honours core back-pressure and a synchronous flush.

## Interface
- `FIFO_DEPTH`, 4: instruction buffer depth; power of two, ≥2.
- `WB_LAT`, 2: cycles from issue to result visible in regfile; legal 2..4.

- `cpu_clk`  in  1  single clock, rising edge.
- `cpu_rst_n`  in  1  reset; asynchronous assert, active-low.
- `flush`  in  1  synchronous clear of buffer and scoreboard.
- `in_instr`  in  32  instruction from fetch.
- `in_valid`  in  1  `in_instr` valid.
- `in_ready`  out  1  buffer can accept.
- `core_busy`  in  1  core cannot take an instruction this cycle.
- `cpu_instruction`  out  32  last issued instruction (registered).
- `cpu_instruction_RDY_BSY`  out  1  one-cycle issue strobe (registered).
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  occupancy.
- `stall_hazard`  out  1  head blocked by scoreboard this cycle.
- `idle`  out  1  FIFO empty and scoreboard clear.

## Operation
- **Push:** `in_valid && in_ready` writes `in_instr` at the tail.
  - `in_ready = !full`. There is no pass-through when full, even if a pop happens in the same cycle.
- **Decode of head:** opcode [6:0], rd [11:7], rs1 [19:15], rs2 [24:20].
  - OP_ITYPE (0010011) reads rs1.
  - OP_RTYPE (0110011) reads rs1 and rs2.
  - Both write rd unless rd==0.
  - Any other opcode reads nothing, writes nothing, and is issued unchanged.
- **Scoreboard:** WB_LAT-1 entries of {valid, rd}, shifted every cycle regardless of `core_busy`.
  - Issue loads entry 0. The oldest entry drops out.
  - Hazard = the head's used rs1/rs2 (nonzero) equals any valid entry's rd.
- **Issue condition:** `!empty && !core_busy && !hazard && !flush`.
  - On issue: pop the head, register it to `cpu_instruction`, and assert the strobe for the following cycle only.
  - When not issuing, `cpu_instruction` holds its value and the strobe is 0.
- **FSM states:**
  - IDLE: FIFO empty.
  - RUN: head eligible, or blocked only by `core_busy`.
  - HAZARD: head blocked by scoreboard; `stall_hazard`=1.
  - Transitions:
    - IDLE→RUN on first push.
    - RUN→HAZARD when hazard.
    - HAZARD→RUN when the blocking entry shifts out.
    - RUN→IDLE when the last entry pops with no push.
    - Any state→IDLE on `flush`.
- **Precedence:** flush beats push. A push in the flush cycle is dropped.
  - Flush clears the FIFO, scoreboard and strobe. `cpu_instruction` is held.
- **Hazard priority:** when both `core_busy` and hazard are true, `stall_hazard` still reports 1.

## Timing
- **Reset values:**
  - `cpu_instruction`=0, `cpu_instruction_RDY_BSY`=0, `fifo_count`=0.
  - `stall_hazard`=0, `idle`=1, `in_ready`=1, FSM=IDLE, scoreboard invalid.
- **Reset mid-operation:** discards all buffered and in-flight state immediately, with no drain.
- **Minimum latency:**
  - Instruction accepted at edge N into an empty FIFO, with no hazard and no busy.
  - It is popped at edge N+1, so the strobe is high in cycle N+1..N+2.
- **Throughput:** one issue per cycle for independent instructions.
- **Dependent issue spacing:** a dependent instruction issues no earlier than WB_LAT edges after its producer's issue edge. With WB_LAT=2 that is one bubble.
- **Occupancy:** `fifo_count` updates at the edge. Simultaneous push and pop leaves it unchanged.

## Configuration
- `ISSUE_PERF_CNT_EN` defined adds two 32-bit outputs, `issue_cnt` and `stall_cnt`:
  - `issue_cnt` increments per strobe.
  - `stall_cnt` increments per cycle with `!empty` and no issue.
  - Both reset to 0, are cleared by `flush`, and wrap at 2^32.
- Undefined: these ports and counters do not exist. Behaviour is otherwise identical.

## Structure
- Package `issue_pkg` holds:
  - OP_ITYPE and OP_RTYPE constants.
  - The FSM state typedef (IDLE/RUN/HAZARD).
  - Field-extract functions for rd, rs1, rs2 and opcode.
- Sub-module `issue_fifo` is a parameterised synchronous FIFO with push/pop/count/full/empty. The scoreboard and FSM live in the top module.

## Test plan
- Reset, then push 0x00500093 (addi x1,x0,5) → strobe exactly one cycle after acceptance with `cpu_instruction`=0x00500093; `idle` returns 1 after WB_LAT cycles.
- WB_LAT=2, push 0x00500093, then 0x00508113 (addi x2,x1,5) back-to-back → strobes 2 cycles apart, `stall_hazard`=1 for 1 cycle.
- Push 0x00500093, then 0x00100293 (addi x5,x0,1) → strobes on consecutive cycles, `stall_hazard` never 1.
- Push 0x002081B3 (add x3,x1,x2), then 0x00317233 (and x4,x2,x3), with x3 the rs2 dependency → second strobe delayed WB_LAT cycles.
- Hold `core_busy`=1 and push 5 instructions with FIFO_DEPTH=4 → `fifo_count`=4, `in_ready`=0, 5th held. Release → 4 strobes on consecutive cycles, then the 5th is accepted and issued.
- Fill with 3 entries, assert `flush` together with `in_valid` → next cycle `fifo_count`=0, `idle`=1, no strobe, pushed word dropped. With `ISSUE_PERF_CNT_EN`, counters read 0.
